// File: rtl/param_slave_mem_if.sv
// Bus bundle for param_slave_mem: write port, read port, clear request and status.
interface param_slave_mem_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic [DATA_W-1:0]   DataIn;
    logic [ADDR_W-1:0]   WrAddrIn;
    logic                Wen;
    logic [DATA_W/8-1:0] ByteEn;
    logic [ADDR_W-1:0]   RdAddrIn;
    logic                Ren;
    logic                Clr;
    logic [DATA_W-1:0]   DataOut;
    logic                RdValid;
    logic                Busy;
    logic                AddrErr;

    modport master (
        output DataIn, WrAddrIn, Wen, ByteEn, RdAddrIn, Ren, Clr,
        input  DataOut, RdValid, Busy, AddrErr
    );

    modport slave (
        input  DataIn, WrAddrIn, Wen, ByteEn, RdAddrIn, Ren, Clr,
        output DataOut, RdValid, Busy, AddrErr
    );
endinterface

// File: rtl/param_slave_mem.sv
// One-write/one-read RAM with byte enables, write-first forwarding, a 1- or 2-cycle
// registered read pipeline and a zero-fill sequencer that runs after reset or on Clr.
module param_slave_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 1
) (
    input logic              Clk,
    input logic              Rst_n,
    param_slave_mem_if.slave bus
);
    localparam int unsigned      BE_W     = DATA_W / 8;
    localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_CMP = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e            state;
    logic [IDX_W-1:0]  ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              wrInRange;
    logic              rdInRange;
    logic              wrFire;
    logic              rdFire;
    logic [IDX_W-1:0]  wrIdx;
    logic [IDX_W-1:0]  rdIdx;
    logic [DATA_W-1:0] oldWord;
    logic [DATA_W-1:0] rdWord;
    logic              memWe;
    logic [IDX_W-1:0]  memIdx;
    logic [DATA_W-1:0] memData;
    logic [BE_W-1:0]   memBe;

    // Decode accesses, build the forwarded read word and select the array write source.
    always_comb begin
        ready     = (state == StReady);
        wrInRange = ({1'b0, bus.WrAddrIn} < DEPTH_CMP);
        rdInRange = ({1'b0, bus.RdAddrIn} < DEPTH_CMP);
        wrIdx     = bus.WrAddrIn[IDX_W-1:0];
        rdIdx     = bus.RdAddrIn[IDX_W-1:0];
        wrFire    = ready && bus.Wen && wrInRange;
        // Out-of-range reads still return a (zero) result with RdValid.
        rdFire    = ready && bus.Ren;
        oldWord   = rdInRange ? mem[rdIdx] : '0;
        rdWord    = oldWord;
        if (wrFire && rdInRange && (bus.WrAddrIn == bus.RdAddrIn)) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (bus.ByteEn[i]) begin
                    rdWord[8*i +: 8] = bus.DataIn[8*i +: 8];
                end
            end
        end
        if (!ready) begin
            memWe   = 1'b1;
            memIdx  = ptr;
            memData = '0;
            memBe   = '1;
        end else begin
            memWe   = wrFire;
            memIdx  = wrIdx;
            memData = bus.DataIn;
            memBe   = bus.ByteEn;
        end
    end

    // Array write port; the array itself is never reset, the sequencer zero-fills it.
    always_ff @(posedge Clk) begin
        if (memWe) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (memBe[i]) begin
                    mem[memIdx][8*i +: 8] <= memData[8*i +: 8];
                end
            end
        end
    end

    // Clear sequencer with registered Busy and AddrErr.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= StInit;
            ptr         <= '0;
            bus.Busy    <= 1'b1;
            bus.AddrErr <= 1'b0;
        end else begin
            bus.AddrErr <= ready && ((bus.Wen && !wrInRange) || (bus.Ren && !rdInRange));
            unique case (state)
                StInit: begin
                    if (ptr == LAST_IDX) begin
                        state    <= StReady;
                        ptr      <= '0;
                        bus.Busy <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                StReady: begin
                    if (bus.Clr) begin
                        state    <= StInit;
                        ptr      <= '0;
                        bus.Busy <= 1'b1;
                    end
                end
                default: begin
                    state    <= StInit;
                    ptr      <= '0;
                    bus.Busy <= 1'b1;
                end
            endcase
        end
    end

    if (RD_LAT == 2) begin : gLat2
        logic [DATA_W-1:0] s1Data;
        logic              s1Valid;

        // Two-stage read pipeline; DataOut holds between results.
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                s1Data      <= '0;
                s1Valid     <= 1'b0;
                bus.DataOut <= '0;
                bus.RdValid <= 1'b0;
            end else begin
                s1Valid     <= rdFire;
                bus.RdValid <= s1Valid;
                if (rdFire) begin
                    s1Data <= rdWord;
                end
                if (s1Valid) begin
                    bus.DataOut <= s1Data;
                end
            end
        end
    end else begin : gLat1
        // Single-stage read pipeline; DataOut holds between results.
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                bus.DataOut <= '0;
                bus.RdValid <= 1'b0;
            end else begin
                bus.RdValid <= rdFire;
                if (rdFire) begin
                    bus.DataOut <= rdWord;
                end
            end
        end
    end
endmodule
